// File: rtl/hcsr04_pkg.sv
// Shared constants, clock-rate helpers and FSM encoding for the HC-SR04 companion logic.
package hcsr04_pkg;

  localparam logic [15:0] HCSR04_DIST_INVALID = 16'hFFFF;

  function automatic int unsigned cycles_per_us(input int unsigned sys_clk_hz);
    return sys_clk_hz / 1_000_000;
  endfunction

  function automatic int unsigned cycles_per_ms(input int unsigned sys_clk_hz);
    return sys_clk_hz / 1_000;
  endfunction

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StStart      = 3'd1,
    StWaitResult = 3'd2,
    StUpdate     = 3'd3,
    StOutput     = 3'd4,
    StHoldoff    = 3'd5
  } state_e;

endpackage

// File: rtl/hcsr04_avg_buf.sv
// Circular sample buffer with running sum; avg_o is the truncated mean of the window.
module hcsr04_avg_buf #(
  parameter int unsigned AvgLog2 = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        prime_i,
  input  logic        push_i,
  input  logic [15:0] sample_i,
  output logic [15:0] avg_o
);

  localparam int unsigned Depth = 1 << AvgLog2;
  localparam int unsigned PtrW  = (AvgLog2 > 0) ? AvgLog2 : 1;
  localparam int unsigned SumW  = 16 + AvgLog2;

  logic [15:0]     mem_q [Depth];
  logic [15:0]     mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SumW-1:0] sum_q, sum_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    sum_d    = sum_q;
    if (prime_i) begin
      // Fill the whole window so the mean equals the first sample immediately
      for (int i = 0; i < Depth; i++) begin
        mem_d[i] = sample_i;
      end
      sum_d = SumW'(sample_i) << AvgLog2;
    end else if (push_i) begin
      mem_d[wr_ptr_q] = sample_i;
      sum_d           = sum_q - SumW'(mem_q[wr_ptr_q]) + SumW'(sample_i);
      wr_ptr_d        = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      sum_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      sum_q    <= sum_d;
    end
  end

  assign avg_o = 16'(sum_q >> AvgLog2);

endmodule

// File: rtl/hcsr04_dist_filter.sv
// Paces HC-SR04 measurements, rejects invalid results, averages good ones and
// drives a hysteretic near-object alarm plus a consecutive-miss fault flag.
module hcsr04_dist_filter
  import hcsr04_pkg::*;
#(
  parameter int unsigned P_SYS_CLK_HZ = 100_000_000,
  parameter int unsigned P_PERIOD_MS  = 60,
  parameter int unsigned P_AVG_LOG2   = 2,
  parameter int unsigned P_NEAR_CM    = 20,
  parameter int unsigned P_HYST_CM    = 3,
  parameter int unsigned P_MAX_MISS   = 3
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEnable,
  output logic        oStart,
  input  logic        iValid,
  input  logic [15:0] iDistance,
  output logic [15:0] oDistance,
  output logic        oValid,
  output logic        oNear,
  output logic        oFault,
  output logic        oBusy
);

  localparam int unsigned LP_PERIOD = P_PERIOD_MS * cycles_per_ms(P_SYS_CLK_HZ);
  localparam int unsigned CntW      = $clog2(LP_PERIOD);
  localparam int unsigned MissW     = $clog2(P_MAX_MISS + 1);

  localparam logic [CntW-1:0]  CntLast  = CntW'(LP_PERIOD - 1);
  localparam logic [MissW-1:0] MissMax  = MissW'(P_MAX_MISS);
  localparam logic [15:0]      NearSet  = 16'(P_NEAR_CM);
  localparam logic [15:0]      NearClr  = 16'(P_NEAR_CM + P_HYST_CM);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [MissW-1:0] miss_q, miss_d;
  logic             fault_q, fault_d;
  logic             primed_q, primed_d;
  logic [15:0]      sample_q, sample_d;
  logic [15:0]      dist_q, dist_d;
  logic             near_q, near_d;
  logic             start_q, start_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic             period_end;
  logic             miss;
  logic             buf_prime;
  logic             buf_push;
  logic [15:0]      avg_dist;

  hcsr04_avg_buf #(
    .AvgLog2 (P_AVG_LOG2)
  ) u_avg_buf (
    .clk_i    (iClk),
    .rst_i    (iRst),
    .prime_i  (buf_prime),
    .push_i   (buf_push),
    .sample_i (sample_q),
    .avg_o    (avg_dist)
  );

  assign period_end = (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    miss_d    = miss_q;
    fault_d   = fault_q;
    primed_d  = primed_q;
    sample_d  = sample_q;
    dist_d    = dist_q;
    near_d    = near_q;
    miss      = 1'b0;
    buf_prime = 1'b0;
    buf_push  = 1'b0;

    // Saturate so a late result can never wrap the counter past the period end
    if (state_q != StIdle && !period_end) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (iEnable) state_d = StStart;
      end
      StStart: begin
        state_d = StWaitResult;
      end
      StWaitResult: begin
        if (iValid) begin
          if (iDistance != HCSR04_DIST_INVALID) begin
            sample_d = iDistance;
            state_d  = StUpdate;
          end else begin
            miss    = 1'b1;
            state_d = StHoldoff;
          end
        end else if (period_end) begin
          miss    = 1'b1;
          state_d = iEnable ? StStart : StIdle;
        end
      end
      StUpdate: begin
        if (!primed_q || fault_q) buf_prime = 1'b1;
        else                      buf_push  = 1'b1;
        primed_d = 1'b1;
        state_d  = StOutput;
      end
      StOutput: begin
        dist_d = avg_dist;
        if (avg_dist < NearSet)       near_d = 1'b1;
        else if (avg_dist >= NearClr) near_d = 1'b0;
        miss_d  = '0;
        fault_d = 1'b0;
        state_d = StHoldoff;
      end
      StHoldoff: begin
        if (period_end) state_d = iEnable ? StStart : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (miss) begin
      miss_d  = (miss_q == MissMax) ? miss_q : miss_q + 1'b1;
      fault_d = (miss_d == MissMax);
    end

    if (state_d == StStart) cnt_d = '0;

    // Pulses trail their state by one cycle so they come straight from flops
    start_d = (state_q == StStart);
    valid_d = (state_q == StOutput);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      miss_q   <= '0;
      fault_q  <= 1'b0;
      primed_q <= 1'b0;
      sample_q <= '0;
      dist_q   <= '0;
      near_q   <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      miss_q   <= miss_d;
      fault_q  <= fault_d;
      primed_q <= primed_d;
      sample_q <= sample_d;
      dist_q   <= dist_d;
      near_q   <= near_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign oStart    = start_q;
  assign oValid    = valid_q;
  assign oDistance = dist_q;
  assign oNear     = near_q;
  assign oFault    = fault_q;
  assign oBusy     = busy_q;

endmodule

// File: tb/tb_hcsr04_dist_filter.sv
// Directed bench for hcsr04_dist_filter with a 1000-cycle measurement period.
module tb_hcsr04_dist_filter;

  logic        iClk;
  logic        iRst;
  logic        iEnable;
  logic        oStart;
  logic        iValid;
  logic [15:0] iDistance;
  logic [15:0] oDistance;
  logic        oValid;
  logic        oNear;
  logic        oFault;
  logic        oBusy;

  int unsigned cyc;
  int          n_checks;
  int          n_pass;

  hcsr04_dist_filter #(
    .P_SYS_CLK_HZ (1_000_000),
    .P_PERIOD_MS  (1)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iEnable   (iEnable),
    .oStart    (oStart),
    .iValid    (iValid),
    .iDistance (iDistance),
    .oDistance (oDistance),
    .oValid    (oValid),
    .oNear     (oNear),
    .oFault    (oFault),
    .oBusy     (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  // Returns at the negedge where oStart is seen high, bounded by a little over one period.
  task automatic wait_start(output int unsigned at_cyc, output bit seen);
    seen   = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge iClk);
      if (oStart) begin
        seen   = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  // One-cycle result strobe; lat = posedges after the sampling edge until oValid, -1 if none.
  task automatic send_result(input logic [15:0] d, output int lat);
    @(negedge iClk);
    iValid    = 1'b1;
    iDistance = d;
    lat       = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      if (i == 0) iValid = 1'b0;
      if (oValid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; iEnable = 1'b0; iValid = 1'b0; iDistance = '0;
    repeat (3) @(negedge iClk);
    n_checks++;
    if ({oStart, oValid, oNear, oFault, oBusy} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {oStart, oValid, oNear, oFault, oBusy});
    else n_pass++;
    n_checks++;
    if (oDistance !== 16'd0) $display("FAIL reset_dist: got %0d want 0", oDistance);
    else n_pass++;
    iRst = 1'b0;
    @(negedge iClk);
    n_checks++;
    if (oBusy !== 1'b0) $display("FAIL idle_busy: got %b want 0", oBusy);
    else n_pass++;
  endtask

  task automatic test_timeouts();
    int unsigned c0, t1, t2, t3, t4;
    bit s;
    iEnable = 1'b1;
    c0 = cyc;
    wait_start(t1, s);
    n_checks++;
    if (!s || (t1 - c0) != 2) $display("FAIL first_start: seen %b after %0d want 2", s, t1 - c0);
    else n_pass++;
    n_checks++;
    if (oBusy !== 1'b1) $display("FAIL busy_run: got %b want 1", oBusy);
    else n_pass++;
    wait_start(t2, s);
    n_checks++;
    if (!s || (t2 - t1) != 1000) $display("FAIL spacing: seen %b got %0d want 1000", s, t2 - t1);
    else n_pass++;
    wait_start(t3, s);
    n_checks++;
    if (!s || oFault !== 1'b0) $display("FAIL fault_2miss: seen %b got %b want 0", s, oFault);
    else n_pass++;
    wait_start(t4, s);
    n_checks++;
    if (!s || oFault !== 1'b1) $display("FAIL fault_3miss: seen %b got %b want 1", s, oFault);
    else n_pass++;
    n_checks++;
    if (oValid !== 1'b0 || oDistance !== 16'd0)
      $display("FAIL timeout_out: valid %b dist %0d want 0 0", oValid, oDistance);
    else n_pass++;
  endtask

  // Runs right after the fourth start of test_timeouts.
  task automatic test_prime();
    int lat;
    send_result(16'd100, lat);
    n_checks++;
    if (lat != 2) $display("FAIL prime_latency: got %0d want 2", lat);
    else n_pass++;
    n_checks++;
    if (oDistance !== 16'd100) $display("FAIL prime_dist: got %0d want 100", oDistance);
    else n_pass++;
    n_checks++;
    if (oFault !== 1'b0 || oNear !== 1'b0)
      $display("FAIL prime_flags: fault %b near %b want 0 0", oFault, oNear);
    else n_pass++;
  endtask

  task automatic test_average();
    int          exp_d [4] = '{125, 150, 175, 200};
    int unsigned t;
    bit          s;
    int          lat;
    for (int k = 0; k < 4; k++) begin
      wait_start(t, s);
      send_result(16'd200, lat);
      n_checks++;
      if (!s || lat != 2 || oDistance !== 16'(exp_d[k]))
        $display("FAIL avg_%0d: seen %b lat %0d dist %0d want lat 2 dist %0d",
                 k, s, lat, oDistance, exp_d[k]);
      else n_pass++;
    end
  endtask

  task automatic test_misses();
    int unsigned t, tp;
    bit          s;
    int          lat;
    tp = 0;
    for (int k = 0; k < 3; k++) begin
      wait_start(t, s);
      if (k == 1) begin
        n_checks++;
        if (!s || (t - tp) != 1000) $display("FAIL miss_spacing: got %0d want 1000", t - tp);
        else n_pass++;
      end
      tp = t;
      send_result(16'hFFFF, lat);
      n_checks++;
      if (!s || lat != -1 || oDistance !== 16'd200)
        $display("FAIL miss_%0d: seen %b lat %0d dist %0d want -1 200", k, s, lat, oDistance);
      else n_pass++;
      n_checks++;
      if (oFault !== (k == 2)) $display("FAIL miss_fault_%0d: got %b want %b", k, oFault, k == 2);
      else n_pass++;
    end
    wait_start(t, s);
    send_result(16'd50, lat);
    n_checks++;
    if (!s || lat != 2 || oDistance !== 16'd50)
      $display("FAIL reprime: seen %b lat %0d dist %0d want 2 50", s, lat, oDistance);
    else n_pass++;
    n_checks++;
    if (oFault !== 1'b0) $display("FAIL reprime_fault: got %b want 0", oFault);
    else n_pass++;
  endtask

  task automatic test_near_and_reset();
    int          raw   [4] = '{19, 27, 23, 23};
    int          exp_d [4] = '{19, 21, 22, 23};
    logic        exp_n [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int unsigned t;
    bit          s;
    int          lat;
    iEnable = 1'b0;
    iRst    = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    iEnable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_start(t, s);
      send_result(16'(raw[k]), lat);
      n_checks++;
      if (!s || lat != 2 || oDistance !== 16'(exp_d[k]) || oNear !== exp_n[k])
        $display("FAIL near_%0d: lat %0d dist %0d near %b want 2 %0d %b",
                 k, lat, oDistance, oNear, exp_d[k], exp_n[k]);
      else n_pass++;
    end
    wait_start(t, s);
    @(negedge iClk);
    iRst = 1'b1;
    #1;
    n_checks++;
    if (!s || {oStart, oValid, oNear, oFault, oBusy} !== 5'b0 || oDistance !== 16'd0)
      $display("FAIL async_reset: flags %b dist %0d want 00000 0",
               {oStart, oValid, oNear, oFault, oBusy}, oDistance);
    else n_pass++;
  endtask

  task automatic test_disable();
    int unsigned t;
    bit          s;
    int          lat;
    int          starts;
    @(negedge iClk);
    iEnable = 1'b1;
    iRst    = 1'b0;
    wait_start(t, s);
    @(negedge iClk);
    iEnable = 1'b0;
    send_result(16'd40, lat);
    n_checks++;
    if (!s || lat != 2 || oDistance !== 16'd40 || oNear !== 1'b0)
      $display("FAIL disable_result: lat %0d dist %0d near %b want 2 40 0", lat, oDistance, oNear);
    else n_pass++;
    starts = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge iClk);
      if (oStart) starts++;
    end
    n_checks++;
    if (starts != 0 || oBusy !== 1'b0)
      $display("FAIL disable_idle: starts %0d busy %b want 0 0", starts, oBusy);
    else n_pass++;
    send_result(16'd5, lat);
    n_checks++;
    if (lat != -1 || oDistance !== 16'd40)
      $display("FAIL spurious_valid: lat %0d dist %0d want -1 40", lat, oDistance);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_timeouts();
    test_prime();
    test_average();
    test_misses();
    test_near_and_reset();
    test_disable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
